// File: rtl/dht11_acq_scheduler.sv
// Periodic DHT11 acquisition sequencer: EN/RST handshake, WAIT timeout, retries, result latching.
// Define DHT_SCHED_RANGE_CHECK_EN to also reject frames with implausible humidity/temperature bytes.
module dht11_acq_scheduler #(
    parameter int CLK_HZ     = 50000000,
    parameter int PERIOD_MS  = 2000,
    parameter int TIMEOUT_MS = 50,
    parameter int MAX_RETRY  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       TRIG,
    output logic       DHT_EN,
    output logic       DHT_RST,
    input  logic       DHT_WAIT,
    input  logic       DHT_ERROR,
    input  logic       DHT_CRC,
    input  logic [7:0] DHT_HUM_INT,
    input  logic [7:0] DHT_HUM_FLOAT,
    input  logic [7:0] DHT_TEMP_INT,
    input  logic [7:0] DHT_TEMP_FLOAT,
    output logic [7:0] HUM_INT,
    output logic [7:0] HUM_FLOAT,
    output logic [7:0] TEMP_INT,
    output logic [7:0] TEMP_FLOAT,
    output logic       VALID,
    output logic       FAIL,
    output logic       STALE,
    output logic       BUSY,
    output logic [7:0] ERR_COUNT
);

    localparam int PERIOD_CYC = CLK_HZ / 1000 * PERIOD_MS;
    localparam int TMO_CYC    = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int MAX_CYC    = (PERIOD_CYC > TMO_CYC) ? PERIOD_CYC : TMO_CYC;
    localparam int TW         = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TMO_CYC - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, RSTS, ARM, XFER, CHECK, HOLDOFF} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tmr, tmr_nx;
    logic          tmo, tmo_nx;
    logic [3:0]    retry, retry_nx;
    logic          retry_pending, retry_pending_nx;
    logic          trig_pending, trig_pending_nx;
    logic          en_nx, rst_nx, busy_nx, valid_nx, fail_nx, stale_nx;
    logic [7:0]    err_nx;
    logic          latch;
    logic          tmo_hit;
    logic          in_range;
    logic          frame_good;

`ifdef DHT_SCHED_RANGE_CHECK_EN
    assign in_range = (DHT_HUM_INT <= 8'd95) && (DHT_TEMP_INT <= 8'd50);
`else
    assign in_range = 1'b1;
`endif

    // One timer serves both the ARM/XFER timeout and the hold-off period; it restarts on entry to each.
    assign tmo_hit    = (tmr == TMO_LAST);
    assign frame_good = !tmo && !DHT_ERROR && DHT_CRC && in_range;

    always_comb begin
        state_nx         = state;
        tmr_nx           = tmr + 1'b1;
        tmo_nx           = tmo;
        retry_nx         = retry;
        retry_pending_nx = retry_pending;
        trig_pending_nx  = trig_pending | (TRIG & (state != IDLE));
        valid_nx         = 1'b0;
        fail_nx          = 1'b0;
        stale_nx         = STALE;
        err_nx           = ERR_COUNT;
        latch            = 1'b0;

        case (state)
            IDLE: begin
                tmr_nx = '0;
                if (START || TRIG)
                    state_nx = RSTS;
            end
            RSTS: begin
                tmr_nx   = '0;
                tmo_nx   = 1'b0;
                state_nx = ARM;
            end
            ARM: begin
                if (tmo_hit) begin
                    tmo_nx   = 1'b1;
                    state_nx = CHECK;
                end else if (DHT_WAIT) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (tmo_hit) begin
                    tmo_nx   = 1'b1;
                    state_nx = CHECK;
                end else if (!DHT_WAIT) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                tmr_nx   = '0;
                state_nx = HOLDOFF;
                if (frame_good) begin
                    latch    = 1'b1;
                    valid_nx = 1'b1;
                    stale_nx = 1'b0;
                    retry_nx = '0;
                end else begin
                    if (ERR_COUNT != 8'hFF)
                        err_nx = ERR_COUNT + 8'd1;
                    if (retry < RETRY_MAX) begin
                        retry_nx         = retry + 4'd1;
                        retry_pending_nx = 1'b1;
                    end else begin
                        fail_nx  = 1'b1;
                        stale_nx = 1'b1;
                        retry_nx = '0;
                    end
                end
            end
            HOLDOFF: begin
                if (tmr == PERIOD_LAST) begin
                    if (retry_pending || START || trig_pending || TRIG) begin
                        state_nx         = RSTS;
                        retry_pending_nx = 1'b0;
                        trig_pending_nx  = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered in step with it.
        en_nx   = (state_nx == RSTS) || (state_nx == ARM) || (state_nx == XFER);
        rst_nx  = (state_nx == RSTS);
        busy_nx = en_nx || (state_nx == CHECK);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            tmr           <= '0;
            tmo           <= 1'b0;
            retry         <= '0;
            retry_pending <= 1'b0;
            trig_pending  <= 1'b0;
            DHT_EN        <= 1'b0;
            DHT_RST       <= 1'b1;
            HUM_INT       <= 8'h00;
            HUM_FLOAT     <= 8'h00;
            TEMP_INT      <= 8'h00;
            TEMP_FLOAT    <= 8'h00;
            VALID         <= 1'b0;
            FAIL          <= 1'b0;
            STALE         <= 1'b1;
            BUSY          <= 1'b0;
            ERR_COUNT     <= 8'h00;
        end else begin
            state         <= state_nx;
            tmr           <= tmr_nx;
            tmo           <= tmo_nx;
            retry         <= retry_nx;
            retry_pending <= retry_pending_nx;
            trig_pending  <= trig_pending_nx;
            DHT_EN        <= en_nx;
            DHT_RST       <= rst_nx;
            VALID         <= valid_nx;
            FAIL          <= fail_nx;
            STALE         <= stale_nx;
            BUSY          <= busy_nx;
            ERR_COUNT     <= err_nx;
            if (latch) begin
                HUM_INT    <= DHT_HUM_INT;
                HUM_FLOAT  <= DHT_HUM_FLOAT;
                TEMP_INT   <= DHT_TEMP_INT;
                TEMP_FLOAT <= DHT_TEMP_FLOAT;
            end
        end
    end

endmodule

// File: tb/tb_dht11_acq_scheduler.sv
// Testbench for dht11_acq_scheduler: scripted DHT11 responder plus a transaction-level outcome model.
`timescale 1ns/1ps
module tb_dht11_acq_scheduler;

    localparam int PERIOD_CYC = 20;
    localparam int TMO_CYC    = 10;
    localparam int MAX_RETRY  = 2;
    localparam logic [31:0] DEF_BYTES = 32'h2A01_1702;

    typedef struct {
        int          rise;
        int          hold;
        logic        crc;
        logic        err;
        logic [31:0] bytes;
    } plan_t;

    typedef struct {
        string       name;
        int          rise;
        int          hold;
        logic        crc;
        logic        err;
        logic [31:0] bytes;
        int          exp_att;
        int          exp_err_inc;
        logic [31:0] exp_data;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       TRIG = 1'b0;
    logic       DHT_EN, DHT_RST;
    logic       DHT_WAIT = 1'b0;
    logic       DHT_ERROR = 1'b0;
    logic       DHT_CRC = 1'b0;
    logic [7:0] DHT_HUM_INT = 8'h00, DHT_HUM_FLOAT = 8'h00, DHT_TEMP_INT = 8'h00, DHT_TEMP_FLOAT = 8'h00;
    logic [7:0] HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT;
    logic       VALID, FAIL, STALE, BUSY;
    logic [7:0] ERR_COUNT;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0, fail_cnt = 0, valid_cyc = 0, fail_cyc = 0;
    int rsts_q[$];
    plan_t plans[$];
    plan_t seq[$];
    plan_t def_plan;
    int m_err = 0;
    logic m_stale = 1'b1;
    logic [31:0] m_data = 32'h0;
    vec_t vecs[11];

    dht11_acq_scheduler #(
        .CLK_HZ(1000), .PERIOD_MS(20), .TIMEOUT_MS(10), .MAX_RETRY(2)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .TRIG(TRIG),
        .DHT_EN(DHT_EN), .DHT_RST(DHT_RST), .DHT_WAIT(DHT_WAIT),
        .DHT_ERROR(DHT_ERROR), .DHT_CRC(DHT_CRC),
        .DHT_HUM_INT(DHT_HUM_INT), .DHT_HUM_FLOAT(DHT_HUM_FLOAT),
        .DHT_TEMP_INT(DHT_TEMP_INT), .DHT_TEMP_FLOAT(DHT_TEMP_FLOAT),
        .HUM_INT(HUM_INT), .HUM_FLOAT(HUM_FLOAT), .TEMP_INT(TEMP_INT), .TEMP_FLOAT(TEMP_FLOAT),
        .VALID(VALID), .FAIL(FAIL), .STALE(STALE), .BUSY(BUSY), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Event recorder: start cycles (EN and RST both high) and result pulses.
    initial forever begin
        @(negedge CLK);
        if (DHT_EN && DHT_RST) rsts_q.push_back(cyc);
        if (VALID) begin valid_cnt++; valid_cyc = cyc; end
        if (FAIL) begin fail_cnt++; fail_cyc = cyc; end
    end

    // Sensor stand-in: on each start, raises WAIT 'rise' cycles into ARM, drops it 'hold' cycles later.
    initial forever begin
        plan_t p;
        @(negedge CLK);
        if (!RST && DHT_EN && DHT_RST) begin
            if (plans.size() > 0) p = plans.pop_front();
            else p = def_plan;
            if (p.rise < 0) begin
                {DHT_HUM_INT, DHT_HUM_FLOAT, DHT_TEMP_INT, DHT_TEMP_FLOAT} = p.bytes;
                DHT_CRC = p.crc;
                DHT_ERROR = p.err;
            end else begin
                repeat (p.rise + 1) @(negedge CLK);
                DHT_WAIT = 1'b1;
                repeat (p.hold) @(negedge CLK);
                {DHT_HUM_INT, DHT_HUM_FLOAT, DHT_TEMP_INT, DHT_TEMP_FLOAT} = p.bytes;
                DHT_CRC = p.crc;
                DHT_ERROR = p.err;
                DHT_WAIT = 1'b0;
            end
        end
    end

    function automatic bit timedOut(plan_t p);
        return (p.rise < 0) || (p.rise + p.hold + 1 >= TMO_CYC);
    endfunction

    function automatic bit attemptGood(plan_t p);
        bit ok;
        ok = !timedOut(p) && !p.err && p.crc;
`ifdef DHT_SCHED_RANGE_CHECK_EN
        ok = ok && (p.bytes[31:24] <= 8'd95) && (p.bytes[15:8] <= 8'd50);
`endif
        return ok;
    endfunction

    // Cycles from the start cycle to hold-off entry: start, ARM/XFER, check.
    function automatic int attemptLen(plan_t p);
        return 2 + (timedOut(p) ? TMO_CYC : p.rise + p.hold + 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one TRIG-initiated acquisition with the attempts in 'seq'; called on a falling edge.
    task automatic applyStimulus(input string tag);
        int n_att, total, trig_cyc, last_len;
        bit exp_valid, exp_fail;
        n_att = 0; total = 0; exp_valid = 0; exp_fail = 0;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            n_att++;
            total += attemptLen(seq[i]) + PERIOD_CYC;
            if (attemptGood(seq[i])) begin
                exp_valid = 1; m_data = seq[i].bytes; m_stale = 1'b0;
                break;
            end
            m_err = (m_err >= 255) ? 255 : m_err + 1;
            if (i == MAX_RETRY) begin exp_fail = 1; m_stale = 1'b1; end
        end
        last_len = attemptLen(seq[n_att-1]);
        plans = seq;
        rsts_q.delete(); valid_cnt = 0; fail_cnt = 0;
        TRIG = 1'b1; trig_cyc = cyc;
        @(negedge CLK); TRIG = 1'b0;
        repeat (total + 5) @(negedge CLK);
        checkOutput({tag, "_starts"}, rsts_q.size(), n_att);
        if (rsts_q.size() > 0) checkOutput({tag, "_first_start"}, rsts_q[0], trig_cyc + 1);
        for (int i = 0; i + 1 < rsts_q.size() && i + 1 < n_att; i++)
            checkOutput({tag, "_spacing"}, rsts_q[i+1] - rsts_q[i], attemptLen(seq[i]) + PERIOD_CYC);
        checkOutput({tag, "_valid_pulses"}, valid_cnt, exp_valid);
        checkOutput({tag, "_fail_pulses"}, fail_cnt, exp_fail);
        if (exp_valid && rsts_q.size() == n_att)
            checkOutput({tag, "_valid_time"}, valid_cyc, rsts_q[n_att-1] + last_len);
        if (exp_fail && rsts_q.size() == n_att)
            checkOutput({tag, "_fail_time"}, fail_cyc, rsts_q[n_att-1] + last_len);
        checkOutput({tag, "_data"}, {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT}, m_data);
        checkOutput({tag, "_err_count"}, ERR_COUNT, m_err);
        checkOutput({tag, "_stale"}, STALE, m_stale);
        checkOutput({tag, "_idle"}, {BUSY, DHT_EN, DHT_RST}, 3'b000);
        plans.delete();
    endtask

    initial begin
        int err_before;
        logic [31:0] data_before;
        plan_t tp;
        def_plan = '{1, 2, 1'b1, 1'b0, DEF_BYTES};

        #1 RST = 1'b1;
        #2;
        checkOutput("reset_dht_rst", DHT_RST, 1'b1);
        checkOutput("reset_outputs", {DHT_EN, VALID, FAIL, STALE, BUSY, ERR_COUNT}, {5'b00010, 8'h00});
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        checkOutput("idle_no_start", rsts_q.size(), 0);
        checkOutput("idle_ctrl", {DHT_EN, DHT_RST, BUSY, VALID, FAIL}, 5'b00000);
        checkOutput("idle_stale", STALE, 1'b1);
        checkOutput("idle_data", {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT}, 32'h0);
        checkOutput("idle_err", ERR_COUNT, 8'h00);

        // Single-frame vectors; any retry uses the responder's default good frame (DEF_BYTES).
        vecs[0]  = '{"good_basic",   3, 5, 1'b1, 1'b0, 32'h3700_1905, 1, 0, 32'h3700_1905};
        vecs[1]  = '{"crc_bad",      3, 5, 1'b0, 1'b0, 32'h3700_1905, 2, 1, DEF_BYTES};
        vecs[2]  = '{"err_flag",     2, 3, 1'b1, 1'b1, 32'h3300_1500, 2, 1, DEF_BYTES};
        vecs[3]  = '{"no_wait",     -1, 1, 1'b1, 1'b0, 32'h3300_1500, 2, 1, DEF_BYTES};
        vecs[4]  = '{"tmo_tie_drop", 4, 5, 1'b1, 1'b0, 32'h3300_1500, 2, 1, DEF_BYTES};
        vecs[5]  = '{"just_in_time", 4, 4, 1'b1, 1'b0, 32'h4102_1803, 1, 0, 32'h4102_1803};
        vecs[6]  = '{"tmo_tie_rise", 9, 1, 1'b1, 1'b0, 32'h3300_1500, 2, 1, DEF_BYTES};
        vecs[7]  = '{"fast",         0, 1, 1'b1, 1'b0, 32'h1000_0500, 1, 0, 32'h1000_0500};
        vecs[10] = '{"range_edge",   1, 1, 1'b1, 1'b0, 32'h5F00_3200, 1, 0, 32'h5F00_3200};
`ifdef DHT_SCHED_RANGE_CHECK_EN
        vecs[8]  = '{"hum_over",     1, 1, 1'b1, 1'b0, 32'h6400_1905, 2, 1, DEF_BYTES};
        vecs[9]  = '{"temp_over",    1, 1, 1'b1, 1'b0, 32'h5F00_3300, 2, 1, DEF_BYTES};
`else
        vecs[8]  = '{"hum_over",     1, 1, 1'b1, 1'b0, 32'h6400_1905, 1, 0, 32'h6400_1905};
        vecs[9]  = '{"temp_over",    1, 1, 1'b1, 1'b0, 32'h5F00_3300, 1, 0, 32'h5F00_3300};
`endif
        for (int v = 0; v < 11; v++) begin
            err_before = m_err;
            tp = '{vecs[v].rise, vecs[v].hold, vecs[v].crc, vecs[v].err, vecs[v].bytes};
            seq.delete();
            seq.push_back(tp); seq.push_back(def_plan); seq.push_back(def_plan);
            applyStimulus(vecs[v].name);
            checkOutput({vecs[v].name, "_attempts"}, rsts_q.size(), vecs[v].exp_att);
            checkOutput({vecs[v].name, "_err_inc"}, ERR_COUNT, err_before + vecs[v].exp_err_inc);
            checkOutput({vecs[v].name, "_latched"}, {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT}, vecs[v].exp_data);
        end

        // Every attempt times out: retries exhaust, data stays, one FAIL.
        err_before = m_err;
        data_before = m_data;
        tp = '{-1, 1, 1'b1, 1'b0, 32'hDEAD_BEEF};
        seq.delete();
        repeat (3) seq.push_back(tp);
        applyStimulus("all_tmo");
        checkOutput("all_tmo_err_inc", ERR_COUNT, err_before + 3);
        checkOutput("all_tmo_one_fail", fail_cnt, 1);
        checkOutput("all_tmo_stale", STALE, 1'b1);
        checkOutput("all_tmo_data_kept", {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT}, data_before);

        // START held: periodic starts; a TRIG during hold-off must not add an acquisition.
        plans.delete(); rsts_q.delete(); valid_cnt = 0;
        plans.push_back('{1, 2, 1'b1, 1'b0, 32'h2100_1400});
        plans.push_back('{1, 2, 1'b1, 1'b0, 32'h2200_1500});
        plans.push_back('{1, 2, 1'b1, 1'b0, 32'h2300_1600});
        START = 1'b1;
        for (int i = 0; i < 100 && valid_cnt == 0; i++) @(negedge CLK);
        checkOutput("start_first_valid", valid_cnt, 1);
        TRIG = 1'b1;
        @(negedge CLK); TRIG = 1'b0;
        for (int i = 0; i < 200 && rsts_q.size() < 3; i++) @(negedge CLK);
        START = 1'b0;
        checkOutput("start_reached_three", rsts_q.size(), 3);
        repeat (60) @(negedge CLK);
        checkOutput("start_total_starts", rsts_q.size(), 3);
        for (int i = 0; i + 1 < rsts_q.size() && i < 2; i++)
            checkOutput("start_period", rsts_q[i+1] - rsts_q[i], 6 + PERIOD_CYC);
        checkOutput("start_valid_count", valid_cnt, 3);
        m_data = 32'h2300_1600; m_stale = 1'b0;
        checkOutput("start_data", {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT}, m_data);
        checkOutput("start_stale", STALE, m_stale);
        plans.delete();

        // Asynchronous reset while the frame is in transfer.
        rsts_q.delete();
        plans.push_back('{0, 8, 1'b1, 1'b0, 32'h3900_1800});
        TRIG = 1'b1;
        @(negedge CLK); TRIG = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("xfer_active", {DHT_EN, DHT_RST, BUSY}, 3'b101);
        #2 RST = 1'b1;
        #1;
        checkOutput("xfer_reset_ctrl", {DHT_EN, DHT_RST, BUSY, VALID}, 4'b0100);
        checkOutput("xfer_reset_state", {STALE, ERR_COUNT, HUM_INT}, {1'b1, 8'h00, 8'h00});
        m_err = 0; m_stale = 1'b1; m_data = 32'h0;
        @(negedge CLK); RST = 1'b0;
        repeat (20) @(negedge CLK);
        checkOutput("xfer_reset_no_restart", rsts_q.size(), 1);
        plans.delete();

        // Randomized acquisitions against the outcome model.
        for (int r = 0; r < 25; r++) begin
            seq.delete();
            for (int i = 0; i <= MAX_RETRY; i++) begin
                tp.rise  = int'($urandom_range(0, 10));
                if (tp.rise == 10) tp.rise = -1;
                tp.hold  = int'($urandom_range(1, 6));
                tp.crc   = ($urandom_range(0, 3) != 0);
                tp.err   = ($urandom_range(0, 9) == 0);
                tp.bytes = {8'($urandom_range(0, 127)), 8'($urandom_range(0, 9)),
                            8'($urandom_range(0, 63)), 8'($urandom_range(0, 9))};
                seq.push_back(tp);
            end
            applyStimulus("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
